cp0_regfile: RTL and testbench

- MIPS CP0 register file in the memory stage.
- Consumes the exception unit's except_type, faulting PC and bad address, and commits the architectural side effects: EXL, EPC, Cause.BD/ExcCode and BadVAddr.
- Produces the Status/Cause/EPC values the exception unit reads next cycle.
- Also provides the mfc0/mtc0 read/write port and the Count/Compare timer.

---
 rtl/cp0defines_pkg.sv | 71 +++++++
 rtl/cp0_timer.sv | 53 +++++
 rtl/cp0_regfile.sv | 120 ++++++++++++
 tb/tb_cp0_regfile.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0defines_pkg.sv
// CP0 shared definitions: register numbers, exception type codes,
// ExcCode values, Status/Cause bit positions and the exception decoder.
package cp0defines;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam logic [31:0] EXC_TYPE_NOEXC = 32'd0;
  localparam logic [31:0] EXC_TYPE_INT   = 32'd1;
  localparam logic [31:0] EXC_TYPE_ADEL  = 32'd4;
  localparam logic [31:0] EXC_TYPE_ADES  = 32'd5;
  localparam logic [31:0] EXC_TYPE_SYS   = 32'd8;
  localparam logic [31:0] EXC_TYPE_BP    = 32'd9;
  localparam logic [31:0] EXC_TYPE_RI    = 32'd10;
  localparam logic [31:0] EXC_TYPE_OV    = 32'd12;
  localparam logic [31:0] EXC_TYPE_ERET  = 32'd14;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0A;
  localparam logic [4:0] EXCCODE_OV   = 5'h0C;

  localparam int IE_BIT  = 0;
  localparam int EXL_BIT = 1;
  localparam int TI_BIT  = 30;
  localparam int BD_BIT  = 31;

  // mtc0-writable Status bits: IM[15:8], EXL, IE
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
    logic       badv;
  } exc_dec_t;

  // ERET and unknown codes decode as not-an-exception
  function automatic exc_dec_t exc_decode(
    input logic [31:0] t
  );
    exc_dec_t d;
    d = '{valid: 1'b1, code: EXCCODE_INT,
          badv: 1'b0};
    unique case (1'b1)
      (t == EXC_TYPE_INT):  d.code = EXCCODE_INT;
      (t == EXC_TYPE_ADEL): begin
        d.code = EXCCODE_ADEL;
        d.badv = 1'b1;
      end
      (t == EXC_TYPE_ADES): begin
        d.code = EXCCODE_ADES;
        d.badv = 1'b1;
      end
      (t == EXC_TYPE_SYS):  d.code = EXCCODE_SYS;
      (t == EXC_TYPE_BP):   d.code = EXCCODE_BP;
      (t == EXC_TYPE_RI):   d.code = EXCCODE_RI;
      (t == EXC_TYPE_OV):   d.code = EXCCODE_OV;
      default:              d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count steps every second cycle, TI latches on match.
// Ports: count/compare write strobes + data in; count, compare, ti out.
// CP0_TIMER_INT_EN enables Compare and TI; otherwise both read as 0.
module cp0_timer
  import cp0defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tog;

  // write wins over the increment; the toggle keeps its own rhythm
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog   <= 1'b0;
      count <= '0;
    end else begin
      tog <= ~tog;
      if (count_we)
        count <= wdata;
      else if (tog)
        count <= count + 32'd1;
    end
  end

`ifdef CP0_TIMER_INT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      compare <= '0;
      ti      <= 1'b0;
    end else if (compare_we) begin
      compare <= wdata;
      ti      <= 1'b0;
    end else if (compare != '0 &&
                 count == compare) begin
      ti <= 1'b1;
    end
  end
`else
  logic unused_cmp;
  assign unused_cmp = compare_we;
  assign compare    = '0;
  assign ti         = 1'b0;
`endif

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: mfc0/mtc0 port, exception/ERET commit, Count/Compare.
// Ports: mtc0 write, mfc0 read, ext_int_i, exception inputs, register outs.
// CP0_TIMER_INT_EN enables Compare and the timer interrupt.
module cp0_regfile
  import cp0defines::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter logic [31:0] PRID_VAL   = 32'h0042_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  ext_int_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  exc_dec_t    dec;
  logic        eret;
  logic        wr;
  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic        bd;
  logic [4:0]  exccode;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic        ti;

  assign dec  = exc_decode(except_type_i);
  assign eret = (except_type_i == EXC_TYPE_ERET);
  // a flushed mtc0 must not touch anything
  assign wr   = we_i & ~dec.valid & ~eret;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr && waddr_i == CP0_COUNT),
    .compare_we (wr && waddr_i == CP0_COMPARE),
    .wdata      (wdata_i),
    .count      (count_o),
    .compare    (compare_o),
    .ti         (ti)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status   <= STATUS_RST;
      epc      <= '0;
      badvaddr <= '0;
      bd       <= 1'b0;
      exccode  <= '0;
      ip_sw    <= '0;
      ip_hw    <= '0;
    end else begin
      ip_hw <= ext_int_i;
      if (dec.valid) begin
        exccode <= dec.code;
        if (!status[EXL_BIT]) begin
          epc <= in_delayslot_i ?
                 pc_i - 32'd4 : pc_i;
          bd  <= in_delayslot_i;
        end
        status[EXL_BIT] <= 1'b1;
        if (dec.badv)
          badvaddr <= badvaddr_i;
      end else if (eret) begin
        status[EXL_BIT] <= 1'b0;
      end else if (wr) begin
        unique case (1'b1)
          (waddr_i == CP0_STATUS):
            status <= (status & ~STATUS_WMASK)
                    | (wdata_i & STATUS_WMASK);
          (waddr_i == CP0_CAUSE):
            ip_sw <= wdata_i[9:8];
          (waddr_i == CP0_EPC):
            epc <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  assign cause_o = {bd, ti, 14'b0,
                    ip_hw[5] | ti, ip_hw[4:0],
                    ip_sw, 1'b0, exccode, 2'b0};

  assign status_o    = status;
  assign epc_o       = epc;
  assign badvaddr_o  = badvaddr;
  assign timer_int_o = ti;

  always_comb begin
    rdata_o = '0;
    unique case (1'b1)
      (raddr_i == CP0_BADVADDR): rdata_o = badvaddr;
      (raddr_i == CP0_COUNT):    rdata_o = count_o;
      (raddr_i == CP0_COMPARE):  rdata_o = compare_o;
      (raddr_i == CP0_STATUS):   rdata_o = status;
      (raddr_i == CP0_CAUSE):    rdata_o = cause_o;
      (raddr_i == CP0_EPC):      rdata_o = epc;
      (raddr_i == CP0_PRID):     rdata_o = PRID_VAL;
      default:                   rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: vector table plus
// hand sequences for timer, Count wrap/write and async reset.
module tb_cp0_regfile;

  localparam int S_STATUS = 0;
  localparam int S_CAUSE  = 1;
  localparam int S_EPC    = 2;
  localparam int S_COUNT  = 3;
  localparam int S_CMP    = 4;
  localparam int S_BADV   = 5;
  localparam int S_RDATA  = 6;
  localparam int S_TI     = 7;
  localparam int S_IP7    = 8;
  localparam int S_CTI    = 9;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  ext_int_i;
  logic [31:0] except_type_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] badvaddr_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;

  cp0_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .raddr_i        (raddr_i),
    .rdata_o        (rdata_o),
    .ext_int_i      (ext_int_i),
    .except_type_i  (except_type_i),
    .pc_i           (pc_i),
    .in_delayslot_i (in_delayslot_i),
    .badvaddr_i     (badvaddr_i),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .count_o        (count_o),
    .compare_o      (compare_o),
    .badvaddr_o     (badvaddr_o),
    .timer_int_o    (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exc;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [4:0]  raddr;
    logic [31:0] e_status;
    logic [31:0] e_cause;
    logic [31:0] e_epc;
    logic [31:0] e_bad;
    logic [31:0] e_rdata;
  } vec_t;

  sb_t  sb[$];
  vec_t tv[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] get(int sel);
    case (sel)
      S_STATUS: return status_o;
      S_CAUSE:  return cause_o;
      S_EPC:    return epc_o;
      S_COUNT:  return count_o;
      S_CMP:    return compare_o;
      S_BADV:   return badvaddr_o;
      S_RDATA:  return rdata_o;
      S_TI:     return {31'b0, timer_int_o};
      S_IP7:    return {31'b0, cause_o[15]};
      S_CTI:    return {31'b0, cause_o[30]};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(string n, int sel,
                      logic [31:0] e);
    sb_t s;
    s.name = n;
    s.sel  = sel;
    s.exp  = e;
    sb.push_back(s);
  endtask

  task automatic drain();
    sb_t s;
    logic [31:0] a;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      a = get(s.sel);
      checks++;
      if (a !== s.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h",
                 s.name, a, s.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i           = 1'b0;
    waddr_i        = '0;
    wdata_i        = '0;
    except_type_i  = '0;
    pc_i           = '0;
    in_delayslot_i = 1'b0;
    badvaddr_i     = '0;
  endtask

  task automatic mtc0(logic [4:0] a,
                      logic [31:0] d);
    idle();
    we_i    = 1'b1;
    waddr_i = a;
    wdata_i = d;
  endtask

  function automatic vec_t mk(
    string n, logic we, logic [4:0] wa,
    logic [31:0] wd, logic [31:0] exc,
    logic [31:0] pc, logic ds,
    logic [31:0] bad, logic [4:0] ra,
    logic [31:0] es, logic [31:0] ec,
    logic [31:0] ee, logic [31:0] eb,
    logic [31:0] er);
    vec_t v;
    v.name = n; v.we = we; v.waddr = wa;
    v.wdata = wd; v.exc = exc; v.pc = pc;
    v.ds = ds; v.bad = bad; v.raddr = ra;
    v.e_status = es; v.e_cause = ec;
    v.e_epc = ee; v.e_bad = eb;
    v.e_rdata = er;
    return v;
  endfunction

  initial begin
    rst       = 1'b0;
    ext_int_i = '0;
    raddr_i   = 5'd15;
    idle();

    // table: name we waddr wdata exc pc ds bad raddr
    //        -> status cause epc badvaddr rdata
    tv.push_back(mk("w_epc", 1, 14, 32'h1234_5678,
      0, 0, 0, 0, 14, 32'h0040_0000, 32'h0,
      32'h1234_5678, 0, 32'h1234_5678));
    tv.push_back(mk("w_status", 1, 12, 32'hFFFF_5AFC,
      0, 0, 0, 0, 12, 32'h0040_5A00, 32'h0,
      32'h1234_5678, 0, 32'h0040_5A00));
    tv.push_back(mk("w_cause", 1, 13, 32'hFFFF_FFFF,
      0, 0, 0, 0, 13, 32'h0040_5A00, 32'h300,
      32'h1234_5678, 0, 32'h300));
    tv.push_back(mk("w_badv_ro", 1, 8, 32'h0000_DEAD,
      0, 0, 0, 0, 8, 32'h0040_5A00, 32'h300,
      32'h1234_5678, 0, 32'h0));
    tv.push_back(mk("w_unmapped", 1, 20, 32'hFFFF,
      0, 0, 0, 0, 20, 32'h0040_5A00, 32'h300,
      32'h1234_5678, 0, 32'h0));
    tv.push_back(mk("sys_ds", 0, 0, 0,
      8, 32'hBFC0_0100, 1, 0, 14, 32'h0040_5A02,
      32'h8000_0320, 32'hBFC0_00FC, 0,
      32'hBFC0_00FC));
    tv.push_back(mk("adel_exl", 0, 0, 0,
      4, 32'h1000, 0, 3, 8, 32'h0040_5A02,
      32'h8000_0310, 32'hBFC0_00FC, 3, 3));
    tv.push_back(mk("eret1", 0, 0, 0,
      14, 0, 0, 0, 12, 32'h0040_5A00,
      32'h8000_0310, 32'hBFC0_00FC, 3,
      32'h0040_5A00));
    tv.push_back(mk("ov_vs_mtc0", 1, 12, 32'h0000_FF01,
      12, 32'h2000, 0, 0, 13, 32'h0040_5A02,
      32'h330, 32'h2000, 3, 32'h330));
    tv.push_back(mk("unk_exc", 1, 14, 32'hCAFE_0000,
      7, 32'h9999, 1, 0, 14, 32'h0040_5A02,
      32'h330, 32'hCAFE_0000, 3, 32'hCAFE_0000));
    tv.push_back(mk("eret2", 0, 0, 0,
      14, 0, 0, 0, 12, 32'h0040_5A00,
      32'h330, 32'hCAFE_0000, 3, 32'h0040_5A00));
    tv.push_back(mk("ades", 0, 0, 0,
      5, 32'h3000, 0, 32'h55, 8, 32'h0040_5A02,
      32'h314, 32'h3000, 32'h55, 32'h55));
    tv.push_back(mk("int_exl", 0, 0, 0,
      1, 32'h4000, 1, 32'h77, 13, 32'h0040_5A02,
      32'h300, 32'h3000, 32'h55, 32'h300));
    tv.push_back(mk("eret_vs_mtc0", 1, 14, 32'hFFFF_0000,
      14, 0, 0, 0, 14, 32'h0040_5A00,
      32'h300, 32'h3000, 32'h55, 32'h3000));
    tv.push_back(mk("prid", 0, 0, 0,
      0, 0, 0, 0, 15, 32'h0040_5A00,
      32'h300, 32'h3000, 32'h55, 32'h0042_0000));
    tv.push_back(mk("bp_ds", 0, 0, 0,
      9, 32'h100, 1, 0, 14, 32'h0040_5A02,
      32'h8000_0324, 32'hFC, 32'h55, 32'hFC));
    tv.push_back(mk("eret3", 0, 0, 0,
      14, 0, 0, 0, 13, 32'h0040_5A00,
      32'h8000_0324, 32'hFC, 32'h55, 32'h8000_0324));
    tv.push_back(mk("ri", 0, 0, 0,
      10, 32'h200, 0, 0, 13, 32'h0040_5A02,
      32'h328, 32'h200, 32'h55, 32'h328));
    tv.push_back(mk("eret4", 0, 0, 0,
      14, 0, 0, 0, 12, 32'h0040_5A00,
      32'h328, 32'h200, 32'h55, 32'h0040_5A00));

    // in reset
    #12;
    push("rst_count", S_COUNT, 32'h0);
    push("rst_status", S_STATUS, 32'h0040_0000);
    drain();

    cyc();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    push("idle_status", S_STATUS, 32'h0040_0000);
    push("idle_count", S_COUNT, 32'd5);
    push("idle_cause", S_CAUSE, 32'h0);
    push("idle_epc", S_EPC, 32'h0);
    push("idle_badv", S_BADV, 32'h0);
    push("idle_ti", S_TI, 32'h0);
    push("idle_prid", S_RDATA, 32'h0042_0000);
    drain();

    foreach (tv[i]) begin
      we_i           = tv[i].we;
      waddr_i        = tv[i].waddr;
      wdata_i        = tv[i].wdata;
      except_type_i  = tv[i].exc;
      pc_i           = tv[i].pc;
      in_delayslot_i = tv[i].ds;
      badvaddr_i     = tv[i].bad;
      raddr_i        = tv[i].raddr;
      push({tv[i].name, ".status"}, S_STATUS,
           tv[i].e_status);
      push({tv[i].name, ".cause"}, S_CAUSE,
           tv[i].e_cause);
      push({tv[i].name, ".epc"}, S_EPC,
           tv[i].e_epc);
      push({tv[i].name, ".badv"}, S_BADV,
           tv[i].e_bad);
      push({tv[i].name, ".rdata"}, S_RDATA,
           tv[i].e_rdata);
      cyc();
      drain();
    end
    idle();

    // hardware interrupt sampling
    ext_int_i = 6'b100101;
    push("ext_ip", S_CAUSE, 32'h0000_9728);
    cyc();
    drain();
    ext_int_i = '0;
    push("ext_clr", S_CAUSE, 32'h0000_0328);
    cyc();
    drain();

    // timer
    mtc0(9, 32'h0);
    cyc();
    mtc0(11, 32'd8);
    cyc();
    idle();
    raddr_i = 5'd11;
`ifdef CP0_TIMER_INT_EN
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
        cyc();
        if (timer_int_o) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) begin
        checks++;
        failures++;
        $display("FAIL ti_wait: got timeout want ti=1");
      end
    end
    push("ti_set", S_TI, 32'h1);
    push("ti_ip7", S_IP7, 32'h1);
    push("ti_cause", S_CTI, 32'h1);
    push("ti_cmp", S_RDATA, 32'd8);
    drain();
    for (int i = 0; i < 3; i++) cyc();
    push("ti_hold", S_TI, 32'h1);
    drain();
    mtc0(11, 32'h1000);
    push("ti_clr", S_TI, 32'h0);
    push("ti_clr_ip7", S_IP7, 32'h0);
    push("ti_cmp2", S_CMP, 32'h1000);
    cyc();
    drain();
    idle();
`else
    for (int i = 0; i < 20; i++) cyc();
    push("noti_ti", S_TI, 32'h0);
    push("noti_ip7", S_IP7, 32'h0);
    push("noti_cmp", S_CMP, 32'h0);
    push("noti_rd", S_RDATA, 32'h0);
    drain();
`endif

    // Count wrap and write priority
    mtc0(9, 32'hFFFF_FFFF);
    push("cnt_load", S_COUNT, 32'hFFFF_FFFF);
    cyc();
    drain();
    idle();
    cyc();
    if (count_o == 32'hFFFF_FFFF) cyc();
    push("cnt_wrap", S_COUNT, 32'h0);
    drain();
    cyc();
    mtc0(9, 32'd100);
    push("cnt_wr_inc", S_COUNT, 32'd100);
    cyc();
    drain();
    idle();
    push("cnt_hold", S_COUNT, 32'd100);
    cyc();
    drain();
    push("cnt_next", S_COUNT, 32'd101);
    cyc();
    drain();

    // async reset mid-cycle
    mtc0(14, 32'h5555_0000);
    cyc();
    idle();
    #2;
    rst = 1'b0;
    #1;
    push("arst_status", S_STATUS, 32'h0040_0000);
    push("arst_count", S_COUNT, 32'h0);
    push("arst_epc", S_EPC, 32'h0);
    push("arst_cause", S_CAUSE, 32'h0);
    push("arst_badv", S_BADV, 32'h0);
    push("arst_ti", S_TI, 32'h0);
    drain();
    #3;
    rst = 1'b1;
    push("post_rst_cnt", S_COUNT, 32'h0);
    cyc();
    drain();
    push("post_rst_cnt2", S_COUNT, 32'h1);
    cyc();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
